// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with the HI/LO register pair.
// MULT/MULTU/DIV/DIVU take 34 cycles (32 CALC + 1 FIX + accept); MTHI/MTLO land when idle.
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] mt_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sgn_q, sgn_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        in_sa, in_sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // Operand signs only matter for the signed ops (op[0] == 0).
  assign in_sa = src_a[31] & ~op[0];
  assign in_sb = src_b[31] & ~op[0];
  assign mag_a = in_sa ? (~src_a + 32'd1) : src_a;
  assign mag_b = in_sb ? (~src_b + 32'd1) : src_b;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : 33'd0);
  // 33-bit partial remainder; the difference fits 32 bits whenever it is taken.
  assign rem_shift = {acc_hi_q, acc_lo_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, b_q};
  assign rem_sub   = rem_shift[31:0] - b_q;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (sgn_q && (sa_q ^ sb_q)) ? (~prod + 64'd1) : prod;
  assign quot_fix = (sgn_q && (sa_q ^ sb_q)) ? (~acc_lo_q + 32'd1) : acc_lo_q;
  assign rem_fix  = (sgn_q && sa_q) ? (~acc_hi_q + 32'd1) : acc_hi_q;

  // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = mt_wdata;
        if (lo_we) lo_d = mt_wdata;
        if (start) begin
          is_div_d = op[1];
          sgn_d    = ~op[0];
          sa_d     = in_sa;
          sb_d     = in_sb;
          a_d      = mag_a;
          b_d      = mag_b;
          acc_hi_d = 32'd0;
          acc_lo_d = op[1] ? mag_a : mag_b;
          cnt_d    = 5'd0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = rem_ge ? rem_sub : rem_shift[31:0];
          acc_lo_d = {acc_lo_q[30:0], rem_ge};
        end else begin
          acc_hi_d = mul_sum[32:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = (sgn_q && sa_q) ? (~a_q + 32'd1) : a_q;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cancel && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the 5-stage CPU. It executes MULT, MULTU, DIV and DIVU over 34 cycles and owns the HI/LO register pair. It services MTHI/MTLO writes and drives `busy` to the pipeline; `busy` is the source of the exe/mem `double_en` indications, so the hazard logic stalls any decode-stage read of HI/LO (register address bit 5 set) while an operation is in flight. It is instantiated beside the EXE-stage ALU.

## Interface

Parameters: none; the datapath is fixed at 32 bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising-edge.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  request a new operation; accepted only in IDLE.
- `op`  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `src_a`  in  32  multiplicand / dividend (rs).
- `src_b`  in  32  multiplier / divisor (rt).
- `cancel`  in  1  exception flush; aborts the operation in flight.
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `mt_wdata`  in  32  data for MTHI/MTLO.
- `busy`  out  1  operation in flight (state != IDLE).
- `done`  out  1  one-cycle pulse: HI/LO now hold the result.
- `hi_rdata`  out  32  current HI register.
- `lo_rdata`  out  32  current LO register.

## Operation

- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE, with `start`=1:
  - Latch `op`, the operand magnitudes and the operand signs. Signed ops take the absolute value; unsigned ops take the raw value.
  - Clear the 5-bit iteration counter and go to CALC.
- CALC runs for 32 cycles, counter 0..31, then goes to FIX.
  - Multiply: unsigned shift-add into a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle, on a 33-bit partial remainder.
- FIX runs for 1 cycle, then IDLE. At the closing edge HI/LO load the sign-corrected result:
  - Product sign = sa^sb, applied as a 64-bit two's-complement negate. {HI,LO} = product.
  - Quotient sign = sa^sb; remainder sign = sa. LO = quotient, HI = remainder.
  - Unsigned ops: no correction.
- Divide by zero (signed and unsigned): special-cased to LO=32'hFFFF_FFFF, HI=`src_a` as latched at start.
- 32'h8000_0000 / 32'hFFFF_FFFF (DIV) gives LO=32'h8000_0000, HI=0, with no trap.
- `start` while busy is ignored; the pipeline never issues it.
- `cancel` in CALC or FIX: next state IDLE, HI/LO unchanged, no `done`. `cancel` outranks FIX's HI/LO write in the same cycle.
- MTHI/MTLO writes at the clock edge when not busy.
  - `hi_we`/`lo_we` while busy are dropped; the bench asserts this never happens.
  - `start` together with `hi_we`/`lo_we` in IDLE: the MT write still lands, and the operation result overwrites it later.
- Reading HI/LO never stalls inside this block; the hazard unit stalls on `busy`.

## Timing

- Reset: state IDLE; `busy`=0, `done`=0, `hi_rdata`=0, `lo_rdata`=0; counter 0. Reset takes effect immediately, mid-operation included, and the operation is discarded.
- `start` sampled in cycle T:
  - `busy`=1 during T+1..T+33: CALC T+1..T+32, FIX T+33.
  - HI/LO updated at the edge ending T+33.
  - `done`=1 during T+34 only (registered).
  - `busy`=0 in T+34, and `hi_rdata`/`lo_rdata` are already valid then.
- Back-to-back operations: a new `start` is accepted in T+34, giving 34 cycles per operation.
- `busy` is purely a function of registered state, with no combinational path from inputs.
- MT writes are visible on `hi_rdata`/`lo_rdata` the cycle after the strobe.
- `cancel` in cycle C: `busy`=0 in C+1, and `start` is accepted in C+1.

## Test plan

- MULT `src_a`=32'hFFFF_FFFD (-3), `src_b`=7 at T -> `busy` high T+1..T+33, `done` at T+34, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001. Immediate second `start` at T+34 is accepted.
- DIV -7 / 2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU 7 / 2 -> LO=3, HI=1. DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0.
- DIVU 32'h1234_5678 / 0 -> LO=32'hFFFF_FFFF, HI=32'h1234_5678. DIV 32'h8000_0001 / 0 -> LO=32'hFFFF_FFFF, HI=32'h8000_0001.
- Preload MTHI=32'hAAAA_AAAA and MTLO=32'h5555_5555, start MULT, `cancel` at T+10 -> `busy`=0 at T+11, no `done`, HI/LO still AAAA_AAAA/5555_5555. New `start` at T+11 completes normally.
- DIV running, `resetn` low at T+5 -> `busy`, `done`, HI, LO all 0 without waiting for a clock edge. After release, a MULT 2 x 3 gives HI=0, LO=6.
